// File: rtl/rr_sched80_pkg.sv
// ---------------------------------------------------------------------------
// rr_sched80_pkg
//   Shared constants, the scheduler state type and a pointer helper for the
//   80-way round-robin scheduler (rr_sched80) and its picker (rr_pick80).
//
//   N_CH      number of requesters (legal indices 0..N_CH-1)
//   IDX_W     width of a channel / grant index
//   HOLD_W    width of the grant hold counter
//   IDX_NONE  out-of-range index; the downstream decoder maps it to all-zero
// ---------------------------------------------------------------------------
package rr_sched80_pkg;

    localparam int N_CH   = 80;
    localparam int IDX_W  = 7;
    localparam int HOLD_W = 8;

    localparam logic [IDX_W-1:0] IDX_NONE = 7'd127;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    // Search pointer that follows a released owner: one past it, wrapping 79->0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? '0 : IDX_W'(idx + 1);
    endfunction

endpackage

// File: rtl/rr_sched80_if.sv
// ---------------------------------------------------------------------------
// rr_sched80_if
//   Request/grant bus between the channel request bus and the scheduler.
//
//   en         scheduling enable (no new grants while low)
//   req        per-channel request levels
//   gnt_done   owner release strobe, meaningful only while gnt_valid=1
//   gnt_valid  a grant is active
//   gnt_idx    granted channel index (decoder input, IDX_NONE when idle)
//   timeout    one-cycle pulse when a grant is force-released by the timeout
//   busy       scheduler is not idle
//
//   master: requester side; slave: scheduler side.
// ---------------------------------------------------------------------------
interface rr_sched80_if;
    import rr_sched80_pkg::*;

    logic              en;
    logic [N_CH-1:0]   req;
    logic              gnt_done;
    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic              timeout;
    logic              busy;

    modport master (
        output en, req, gnt_done,
        input  gnt_valid, gnt_idx, timeout, busy
    );

    modport slave (
        input  en, req, gnt_done,
        output gnt_valid, gnt_idx, timeout, busy
    );

endinterface

// File: rtl/rr_pick80.sv
// ---------------------------------------------------------------------------
// rr_pick80
//   Combinational round-robin picker over 80 request lines. Returns the first
//   set request at or above ptr, wrapping from channel 79 back to channel 0.
//
//   req       in   request levels
//   ptr       in   search start index (values >= N_CH are treated as 0)
//   pick_idx  out  chosen channel (IDX_NONE when nothing is requesting)
//   pick_vld  out  at least one request is set
// ---------------------------------------------------------------------------
module rr_pick80
    import rr_sched80_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [IDX_W-1:0]  base;
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [IDX_W-1:0]  off;
    logic [IDX_W:0]    sum;

    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        base     = (ptr < IDX_W'(N_CH)) ? ptr : '0;
        // Rotating a doubled copy right by base puts channel base at bit 0
        // while keeping the 80-wide wrap (80 is not a power of two).
        dbl      = {req, req} >> base;
        rot      = dbl[N_CH-1:0];
        off      = '0;
        pick_vld = 1'b0;
        // Scan downward so the lowest set bit of the rotated vector wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off      = IDX_W'(i);
                pick_vld = 1'b1;
            end
        end
        // Undo the rotation modulo 80; base and off are both < 80, so one
        // conditional subtraction is enough.
        sum = {1'b0, off} + {1'b0, base};
        if (!pick_vld) begin
            pick_idx = IDX_NONE;
        end else if (sum >= (IDX_W + 1)'(N_CH)) begin
            pick_idx = IDX_W'(sum - (IDX_W + 1)'(N_CH));
        end else begin
            pick_idx = sum[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/rr_sched80.sv
// ---------------------------------------------------------------------------
// rr_sched80
//   Round-robin scheduler sharing one resource slot among 80 requesters.
//   Grants one channel at a time and holds it until the owner pulses
//   gnt_done, its request drops, or the hold timeout expires. Every release
//   is followed by one GAP cycle so the decoder sees an all-zero cycle
//   between owners; the next pick happens in the following IDLE cycle.
//
//   MAX_HOLD  maximum grant length in cycles (0 disables the timeout)
//
//   clk       system clock
//   rst       synchronous active-high reset
//   bus       rr_sched80_if.slave: en, req, gnt_done in;
//             gnt_valid, gnt_idx, timeout, busy out
// ---------------------------------------------------------------------------
module rr_sched80
    import rr_sched80_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 200
)
(
    input  logic          clk,
    input  logic          rst,
    rr_sched80_if.slave   bus
);

    localparam logic              HOLD_EXP_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_EXP    = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT    = '1;

    state_t            state_q,     state_d;
    logic [IDX_W-1:0]  ptr_q,       ptr_d;
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic [IDX_W-1:0]  gnt_idx_q,   gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q,   timeout_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;
    logic              owner_drop;
    logic              hold_expire;

    rr_pick80 u_pick (
        .req      (bus.req),
        .ptr      (ptr_q),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Voluntary release (owner done or request gone) versus forced release.
    // Only a forced release with no voluntary cause raises the timeout pulse.
    assign owner_drop  = bus.gnt_done || !bus.req[gnt_idx_q];
    assign hold_expire = HOLD_EXP_EN && (hold_q == HOLD_EXP);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.en && pick_vld) begin
                    state_d     = GRANT;
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    hold_d      = '0;
                end
            end

            // en is deliberately ignored here: dropping it never cuts a grant.
            GRANT: begin
                if (owner_drop || hold_expire) begin
                    state_d     = GAP;
                    gnt_valid_d = 1'b0;
                    gnt_idx_d   = IDX_NONE;
                    ptr_d       = next_ptr(gnt_idx_q);
                    hold_d      = '0;
                    timeout_d   = hold_expire && !owner_drop;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: reset is tested inside the clocked block, so it only takes effect
    // on a rising clk edge; a reset mid-grant therefore never pulses timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_idx_q   <= IDX_NONE;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
